trig_out_fifo: RTL and testbench
================================

TRIG_OUT_FIFO -- requirements
Module: trig_out_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO entries (power of 2, 4..256).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, trigger word width.
REQ-003 SHALL have parameter CNT_WIDTH, default 16, drop-counter width.
REQ-004 SHALL use one clock and an asynchronous, active-low reset, with these ports:
- ifclk  in  1  sole clock.
- ifclk_rst_n_i  in  1  asynchronous, active-low reset.
- runrst_i  in  1  run reset pulse (ifclk domain).
- runstop_i  in  1  run stop pulse.
- s_trig_tdata  in  DATA_WIDTH  trigger word from the generator.
- s_trig_tvalid  in  1  input word valid.
- s_trig_tready  out  1  always 1 outside reset.
- m_trig_tdata  out  DATA_WIDTH  buffered word to the link.
- m_trig_tvalid  out  1  output valid.
- m_trig_tready  in  1  link ready.
- count_o  out  log2(DEPTH)+1  occupancy.
- overflow_o  out  1  sticky, set on any dropped word.
- drop_count_o  out  CNT_WIDTH  dropped words (saturating).
- high_water_o  out  log2(DEPTH)+1  peak occupancy since last runrst.

Function
REQ-005 SHALL implement a two-state FSM: STOPPED and RUNNING.
REQ-006 SHALL, in STOPPED, discard input words without writing, counting or flagging them; stored words still drain.
REQ-007 SHALL, on runrst_i, flush the FIFO in the same cycle (pointers and count to 0; m_trig_tvalid low next cycle), clear overflow_o, drop_count_o and high_water_o, discard any concurrent input word, and enter RUNNING.
REQ-008 SHALL enter STOPPED on runstop_i; runstop_i and runrst_i together flush and then leave the FSM in STOPPED.
REQ-009 SHALL, in RUNNING, write s_trig_tdata when s_trig_tvalid is high and the FIFO is not full, or when it is full and a pop occurs in the same cycle.
REQ-010 SHALL drop a word arriving at a full FIFO with no concurrent pop, set overflow_o, and increment drop_count_o, saturating at all-ones.
REQ-011 SHALL register the output: a word written in cycle N is presented on m_trig_tvalid/m_trig_tdata in cycle N+1 at the earliest, with no combinational input-to-output path.
REQ-012 SHALL pop on m_trig_tvalid && m_trig_tready and hold m_trig_tdata stable while tvalid is high and tready is low.
REQ-013 SHALL preserve strict FIFO order; pointers wrap modulo DEPTH.
REQ-014 SHALL keep count_o exact: +1 on a lone push, -1 on a lone pop, unchanged on a simultaneous push and pop.
REQ-015 SHALL raise high_water_o to count_o whenever count_o exceeds it.

Reset
REQ-016 SHALL, on ifclk_rst_n_i low, asynchronously force: FSM STOPPED, FIFO empty, m_trig_tvalid 0, m_trig_tdata 0, s_trig_tready 0, count_o 0, overflow_o 0, drop_count_o 0, high_water_o 0.
REQ-017 SHALL release reset synchronously to ifclk, with s_trig_tready going to 1 on the first cycle after deassertion.

Configuration
REQ-018 SHALL, with macro TRIG_FIFO_STATS_EN defined, implement drop_count_o and high_water_o as specified.
REQ-019 SHALL, without TRIG_FIFO_STATS_EN, tie drop_count_o and high_water_o to 0 with no counter logic; overflow_o and all other behaviour are unchanged.

Verification
REQ-020 Reset, runrst_i, 3 words 0xA1,0xA2,0xA3 with m_trig_tready=1 -> same order out, each one cycle after its write; count_o returns to 0.
REQ-021 DEPTH=16, m_trig_tready=0, 20 words in RUNNING -> count_o=16, 4 dropped, overflow_o=1, drop_count_o=4 (macro on) or 0 (off); after drain, outputs are words 1..16.
REQ-022 Full FIFO, push and pop in the same cycle -> push accepted, count_o stays 16, drop_count_o unchanged.
REQ-023 5 words stored, runstop_i, then 3 more input words -> the 5 drain, the 3 are discarded, overflow_o stays 0.
REQ-024 10 words stored, high_water_o=10, pulse runrst_i with a concurrent input word -> m_trig_tvalid=0 next cycle; count_o, high_water_o, drop_count_o and overflow_o all 0; the concurrent word is lost.
REQ-025 Assert ifclk_rst_n_i mid-transfer with m_trig_tvalid=1 -> all outputs 0 immediately, without a clock edge.

Source files
------------

// File: rtl/trig_out_fifo_if.sv
// -----------------------------------------------------------------------------
// trig_out_fifo_if
// Bundles the two streaming handshakes of the trigger output FIFO.
//   s_trig_*  : trigger words from the generator into the FIFO
//               (tdata, tvalid toward the FIFO; tready back to the generator)
//   m_trig_*  : buffered words from the FIFO to the link
//               (tdata, tvalid toward the link; tready back to the FIFO)
// Modports:
//   slave  - the FIFO's view (consumes s_trig_*, produces m_trig_*)
//   master - the environment's view (produces s_trig_*, consumes m_trig_*)
// -----------------------------------------------------------------------------
interface trig_out_fifo_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] s_trig_tdata;
    logic                  s_trig_tvalid;
    logic                  s_trig_tready;
    logic [DATA_WIDTH-1:0] m_trig_tdata;
    logic                  m_trig_tvalid;
    logic                  m_trig_tready;

    modport slave (
        input  s_trig_tdata,
        input  s_trig_tvalid,
        output s_trig_tready,
        output m_trig_tdata,
        output m_trig_tvalid,
        input  m_trig_tready
    );

    modport master (
        output s_trig_tdata,
        output s_trig_tvalid,
        input  s_trig_tready,
        input  m_trig_tdata,
        input  m_trig_tvalid,
        output m_trig_tready
    );
endinterface

// File: rtl/trig_out_fifo.sv
// -----------------------------------------------------------------------------
// trig_out_fifo
// Buffers trigger words between the trigger generator and the readout link.
// The input side never back-pressures: words that find the FIFO full are
// dropped and accounted for. A two-state run FSM (STOPPED / RUNNING) gates
// whether incoming words are accepted; stored words always drain.
//
// Ports:
//   ifclk          - sole clock
//   ifclk_rst_n_i  - asynchronous, active-low reset
//   runrst_i       - run reset pulse: flush, clear stats, enter RUNNING
//   runstop_i      - run stop pulse: enter STOPPED (wins over runrst_i)
//   trig           - trig_out_fifo_if.slave (s_trig_* in, m_trig_* out)
//   count_o        - current occupancy
//   overflow_o     - sticky, set when any word is dropped
//   drop_count_o   - saturating count of dropped words
//   high_water_o   - peak occupancy since the last run reset
//
// Configuration:
//   TRIG_FIFO_STATS_EN - when defined, drop_count_o and high_water_o are
//                        implemented; otherwise both are tied to zero.
// -----------------------------------------------------------------------------
module trig_out_fifo #(
    parameter int DEPTH      = 16,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                     ifclk,
    input  logic                     ifclk_rst_n_i,
    input  logic                     runrst_i,
    input  logic                     runstop_i,
    trig_out_fifo_if.slave           trig,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     overflow_o,
    output logic [CNT_WIDTH-1:0]     drop_count_o,
    output logic [$clog2(DEPTH):0]   high_water_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    typedef enum logic {
        ST_STOPPED = 1'b0,
        ST_RUNNING = 1'b1
    } state_t;

    state_t state_q, state_d;
    logic   running;

    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [AW:0]           count_q, count_d;
    logic                  ovf_q, ovf_d;
    logic                  rdy_q;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic full, not_empty, push, pop, drop;

    // ---------------- run FSM: state register ----------------
    always_ff @(posedge ifclk or negedge ifclk_rst_n_i) begin
        if (!ifclk_rst_n_i) begin
            state_q <= ST_STOPPED;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- run FSM: next state ----------------
    // A stop pulse overrides a concurrent run reset: the flush still happens
    // (handled in the datapath) but the FSM ends up STOPPED.
    always_comb begin
        state_d = state_q;
        if (runstop_i) begin
            state_d = ST_STOPPED;
        end else if (runrst_i) begin
            state_d = ST_RUNNING;
        end
    end

    // ---------------- run FSM: outputs ----------------
    always_comb begin
        running = (state_q == ST_RUNNING);
    end

    // ---------------- handshake decode ----------------
    assign not_empty = (count_q != '0);
    assign full      = (count_q == FULL_CNT);
    assign pop       = not_empty && trig.m_trig_tready && !runrst_i;
    // A full FIFO still accepts a word when the head leaves in the same cycle.
    assign push      = running && trig.s_trig_tvalid && (!full || pop) && !runrst_i;
    assign drop      = running && trig.s_trig_tvalid && full && !pop && !runrst_i;

    // ---------------- pointer / occupancy next state ----------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (runrst_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
        end else begin
            // Pointers are exactly AW bits wide, so they wrap modulo DEPTH.
            if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
            if (drop) ovf_d = 1'b1;
        end
    end

    always_ff @(posedge ifclk or negedge ifclk_rst_n_i) begin
        if (!ifclk_rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            rdy_q    <= 1'b1;
        end
    end

    // Storage carries no reset; validity is tracked entirely by count_q.
    always_ff @(posedge ifclk) begin
        if (push) mem[wr_ptr_q] <= trig.s_trig_tdata;
    end

    // Output is driven only from flops (count/pointer registers and storage),
    // so a word written at edge N appears in cycle N+1 and nothing on the
    // input side reaches it combinationally. The head entry is never
    // overwritten while it is presented unless it is popped at the same edge.
    assign trig.m_trig_tvalid = not_empty;
    assign trig.m_trig_tdata  = not_empty ? mem[rd_ptr_q] : '0;
    assign trig.s_trig_tready = rdy_q;
    assign count_o            = count_q;
    assign overflow_o         = ovf_q;

`ifdef TRIG_FIFO_STATS_EN
    logic [CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;
    logic [AW:0]          hw_q, hw_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        hw_d       = hw_q;
        if (runrst_i) begin
            drop_cnt_d = '0;
            hw_d       = '0;
        end else begin
            if (drop && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + CNT_WIDTH'(1);
            // Track against the next occupancy so the peak never lags count_o.
            if (count_d > hw_q) hw_d = count_d;
        end
    end

    always_ff @(posedge ifclk or negedge ifclk_rst_n_i) begin
        if (!ifclk_rst_n_i) begin
            drop_cnt_q <= '0;
            hw_q       <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
            hw_q       <= hw_d;
        end
    end

    assign drop_count_o = drop_cnt_q;
    assign high_water_o = hw_q;
`else
    assign drop_count_o = '0;
    assign high_water_o = '0;
`endif

endmodule

// File: tb/tb_trig_out_fifo.sv
module tb_trig_out_fifo;

    localparam int DEPTH      = 16;
    localparam int DATA_WIDTH = 32;
    localparam int CNT_WIDTH  = 4;
    localparam int DROP_MAX   = (1 << CNT_WIDTH) - 1;

    logic ifclk = 1'b0;
    logic ifclk_rst_n_i;
    logic runrst_i;
    logic runstop_i;
    logic [$clog2(DEPTH):0] count_o;
    logic                   overflow_o;
    logic [CNT_WIDTH-1:0]   drop_count_o;
    logic [$clog2(DEPTH):0] high_water_o;

    trig_out_fifo_if #(.DATA_WIDTH(DATA_WIDTH)) trig ();

    trig_out_fifo #(
        .DEPTH(DEPTH),
        .DATA_WIDTH(DATA_WIDTH),
        .CNT_WIDTH(CNT_WIDTH)
    ) dut (
        .ifclk(ifclk),
        .ifclk_rst_n_i(ifclk_rst_n_i),
        .runrst_i(runrst_i),
        .runstop_i(runstop_i),
        .trig(trig.slave),
        .count_o(count_o),
        .overflow_o(overflow_o),
        .drop_count_o(drop_count_o),
        .high_water_o(high_water_o)
    );

    always #5 ifclk = ~ifclk;

    // Reference model: contents as a queue plus run/stat bookkeeping.
    logic [DATA_WIDTH-1:0] q_m[$];
    bit m_run, m_ovf, m_rdy;
    int m_drops, m_hw;

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        q_m.delete();
        m_run = 1'b0; m_ovf = 1'b0; m_rdy = 1'b0;
        m_drops = 0; m_hw = 0;
    endtask

    task automatic model_edge(input bit rr, input bit rs, input bit v,
                              input logic [DATA_WIDTH-1:0] d, input bit rdy);
        bit pop, full;
        m_rdy = 1'b1;
        if (rr) begin
            q_m.delete();
            m_ovf = 1'b0; m_drops = 0; m_hw = 0;
            m_run = !rs;
            return;
        end
        pop  = (q_m.size() != 0) && rdy;
        full = (q_m.size() == DEPTH);
        if (pop) void'(q_m.pop_front());
        if (m_run && v) begin
            if (!full || pop) q_m.push_back(d);
            else begin
                m_ovf = 1'b1;
                if (m_drops < DROP_MAX) m_drops++;
            end
        end
        if (rs) m_run = 1'b0;
        if (q_m.size() > m_hw) m_hw = q_m.size();
    endtask

    task automatic check_all(input string tag);
        int exp_drops, exp_hw;
`ifdef TRIG_FIFO_STATS_EN
        exp_drops = m_drops;
        exp_hw    = m_hw;
`else
        exp_drops = 0;
        exp_hw    = 0;
`endif
        chk({tag, ".tready"}, 64'(trig.s_trig_tready), 64'(m_rdy));
        chk({tag, ".tvalid"}, 64'(trig.m_trig_tvalid), 64'(q_m.size() != 0));
        chk({tag, ".tdata"},  64'(trig.m_trig_tdata),  (q_m.size() != 0) ? 64'(q_m[0]) : 64'd0);
        chk({tag, ".count"},  64'(count_o),            64'(q_m.size()));
        chk({tag, ".ovf"},    64'(overflow_o),         64'(m_ovf));
        chk({tag, ".drops"},  64'(drop_count_o),       64'(exp_drops));
        chk({tag, ".hw"},     64'(high_water_o),       64'(exp_hw));
    endtask

    // One clock cycle: drive inputs, let the edge happen, update model, check.
    task automatic step(input bit rr, input bit rs, input bit v,
                        input logic [DATA_WIDTH-1:0] d, input bit rdy, input string tag);
        runrst_i = rr;
        runstop_i = rs;
        trig.s_trig_tvalid = v;
        trig.s_trig_tdata  = d;
        trig.m_trig_tready = rdy;
        @(posedge ifclk);
        model_edge(rr, rs, v, d, rdy);
        #1;
        check_all(tag);
    endtask

    initial begin
        ifclk_rst_n_i = 1'b0;
        runrst_i = 1'b0;
        runstop_i = 1'b0;
        trig.s_trig_tvalid = 1'b0;
        trig.s_trig_tdata  = '0;
        trig.m_trig_tready = 1'b0;
        model_reset();

        // Reset state
        repeat (3) @(posedge ifclk);
        #1;
        check_all("reset");
        @(negedge ifclk);
        ifclk_rst_n_i = 1'b1;
        #1;
        check_all("release");
        @(posedge ifclk);
        #1;
        model_edge(1'b0, 1'b0, 1'b0, '0, 1'b0);
        check_all("first_cycle");

        // STOPPED after reset: input ignored
        step(0, 0, 1, 32'hDEAD, 1, "stopped_in");

        // Three words in order, tready high
        step(1, 0, 0, 0, 1, "runrst");
        step(0, 0, 1, 32'hA1, 1, "a1");
        step(0, 0, 1, 32'hA2, 1, "a2");
        step(0, 0, 1, 32'hA3, 1, "a3");
        step(0, 0, 0, 0, 1, "a_drain0");
        step(0, 0, 0, 0, 1, "a_drain1");

        // Overflow: 20 words into a 16-deep FIFO with link stalled
        for (int i = 1; i <= 20; i++) step(0, 0, 1, 32'(i), 0, "fill");
        // Push and pop together at full
        step(0, 0, 1, 32'h100, 1, "full_pushpop");
        step(0, 0, 0, 0, 0, "full_hold");
        // Drop saturation
        for (int i = 0; i < 14; i++) step(0, 0, 1, 32'h200 + 32'(i), 0, "sat");
        for (int i = 0; i < 18; i++) step(0, 0, 0, 0, 1, "drain");

        // Stop: stored words drain, later inputs discarded
        step(1, 0, 0, 0, 0, "runrst2");
        for (int i = 0; i < 5; i++) step(0, 0, 1, 32'h300 + 32'(i), 0, "store5");
        step(0, 1, 0, 0, 0, "runstop");
        for (int i = 0; i < 3; i++) step(0, 0, 1, 32'h400 + 32'(i), 0, "discard");
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 1, "drain5");

        // Run reset flushes, clears stats and loses the concurrent word
        step(1, 0, 0, 0, 0, "runrst3");
        for (int i = 0; i < 10; i++) step(0, 0, 1, 32'h500 + 32'(i), 0, "store10");
        step(1, 0, 1, 32'h5FF, 1, "runrst_flush");
        step(0, 0, 0, 0, 1, "after_flush");

        // runstop and runrst together: flush and stay STOPPED
        step(0, 0, 1, 32'h600, 0, "pre_both");
        step(1, 1, 1, 32'h601, 0, "both");
        step(0, 0, 1, 32'h602, 0, "both_after");

        // Randomized traffic
        step(1, 0, 0, 0, 0, "runrst_rand");
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 1),
                 ($urandom_range(0, 3) != 0), $urandom, ($urandom_range(0, 9) < 4), "rand");
        end

        // Asynchronous reset mid-transfer
        step(1, 0, 0, 0, 0, "runrst_mid");
        for (int i = 0; i < 4; i++) step(0, 0, 1, 32'h700 + 32'(i), 0, "mid_fill");
        #3;
        ifclk_rst_n_i = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
